gelato_fetch_scheduler: RTL and testbench
=========================================

Name: gelato_fetch_scheduler

Overview:
Warp fetch scheduler between the per-warp PC table and the instruction fetch unit. Each cycle it picks one eligible warp by round-robin and presents that warp's PC, warp number and split-table number on a valid/ready request to I-Fetch. It tracks one outstanding fetch per warp, and a warp becomes eligible again only after I-Fetch reports that warp's instruction delivered to decode.

Parameters:
NUM_WARPS, 8, number of warps scheduled; power of two, at least 2
PC_WIDTH, 32, PC width in bits
SPLIT_WIDTH, 2, split-table index width
WARP_WIDTH, $clog2(NUM_WARPS), warp number width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; when low, all state except in-flight clears is frozen
warp_active  in  NUM_WARPS  per-warp "PC table entry runnable"
warp_pc  in  NUM_WARPS*PC_WIDTH  flattened PCs, warp i at bits [i*PC_WIDTH +: PC_WIDTH]
warp_split  in  NUM_WARPS*SPLIT_WIDTH  flattened split-table numbers
fetch_valid  out  1  request to I-Fetch valid
fetch_pc  out  PC_WIDTH  requested PC
fetch_warp_num  out  WARP_WIDTH  requesting warp
fetch_split_table_num  out  SPLIT_WIDTH  split-table number of the request
fetch_ready  in  1  I-Fetch accepts the request
fetch_done  in  1  one-cycle pulse: an instruction was delivered to decode
fetch_done_warp  in  WARP_WIDTH  warp of that delivery
sched_grant  out  NUM_WARPS  one-hot, one-cycle pulse on acceptance; PC table advances that warp's PC

Behaviour:
- Reset: fetch_valid=0, fetch_pc=0, fetch_warp_num=0, fetch_split_table_num=0, sched_grant=0, inflight=0, rr_ptr=0, state=IDLE.
- Eligibility of warp i is warp_active[i] & ~inflight[i], using registered inflight.
- Round-robin: search starts at rr_ptr and wraps modulo NUM_WARPS. rr_ptr <= selected+1 (wrapping) on acceptance only.
- State IDLE, rdy=1, at least one eligible warp:
  - latch that warp's pc, split and number into the fetch_* registers.
  - fetch_valid=1 the next cycle; go to REQ.
  - 1-cycle latency from eligibility to fetch_valid.
- State REQ: fetch_* outputs held stable while fetch_ready=0. When fetch_ready=1 and rdy=1:
  - fetch_valid <= 0.
  - inflight[warp] <= 1.
  - sched_grant <= onehot(warp) for exactly one cycle.
  - state returns to IDLE.
  - Minimum spacing between two accepted requests is 2 cycles.
- Outputs are not re-sampled from warp_pc while in REQ. A warp that deactivates during REQ is still completed.
- fetch_done clears inflight[fetch_done_warp] on every cycle, regardless of rdy.
- fetch_done for a warp whose inflight bit is already 0 is a no-op.
- Simultaneous set and clear of the same warp's inflight bit: set wins; such a done is a protocol violation and fires an assertion in simulation.
- A cleared warp becomes eligible the cycle after fetch_done, so a warp's done-to-request turnaround is at least 2 cycles.
- rdy=0 freezes state, rr_ptr and the fetch_* registers. sched_grant is forced to 0 while rdy=0.
- No eligible warp: stay in IDLE with fetch_valid=0.
- Asserting rst_n low mid-request aborts immediately: all registers return to their reset values, and the outstanding I-Fetch transaction is abandoned.
- Illegal state: $fatal in simulation; synthesis recovers to IDLE.

Optional Feature:
GELATO_FETCH_SKD_PERF_EN
- Defined: adds outputs perf_issue_cnt[31:0] and perf_idle_cnt[31:0], both reset to 0 and frozen when rdy=0.
  - perf_issue_cnt increments once per accepted request.
  - perf_idle_cnt increments on each IDLE cycle with rdy=1 and no eligible warp.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then warp_active=8'b0000_0100 with warp 2 pc=0x100 and fetch_ready=1 -> fetch_valid rises 1 cycle later with fetch_pc=0x100 and warp_num=2; sched_grant=8'h04 for one cycle; warp 2 is not re-issued until fetch_done with warp 2.
- All 8 warps active, fetch_ready=1, every fetch answered by fetch_done 1 cycle after acceptance -> grant order 0,1,2,...,7,0, with one request every 2 cycles while warps are eligible.
- fetch_ready held 0 for 5 cycles while warp_pc[3] changes -> fetch_pc stays at the originally latched value; accepted in cycle 6; single grant pulse.
- rdy=0 for 3 cycles during REQ, with fetch_done for warp 1 in that window -> outputs frozen and no grant; inflight[1] cleared; warp 1 eligible after rdy returns.
- rst_n asserted low while fetch_valid=1 -> fetch_valid=0 and inflight=0 immediately; after release the scheduler restarts from warp 0.
- With GELATO_FETCH_SKD_PERF_EN: 10 accepted requests and 4 empty idle cycles -> perf_issue_cnt=10 and perf_idle_cnt=4.

Source files
------------

// File: rtl/gelato_fetch_scheduler.sv
// Round-robin warp fetch scheduler feeding I-Fetch, one outstanding fetch per warp.
// Optional perf counters enabled by GELATO_FETCH_SKD_PERF_EN.
module gelato_fetch_scheduler #(
  parameter int NUM_WARPS   = 8,
  parameter int PC_WIDTH    = 32,
  parameter int SPLIT_WIDTH = 2,
  localparam int WARP_WIDTH = $clog2(NUM_WARPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic [NUM_WARPS-1:0]          warp_active,
  input  logic [NUM_WARPS*PC_WIDTH-1:0] warp_pc,
  input  logic [NUM_WARPS*SPLIT_WIDTH-1:0] warp_split,
  output logic                          fetch_valid,
  output logic [PC_WIDTH-1:0]           fetch_pc,
  output logic [WARP_WIDTH-1:0]         fetch_warp_num,
  output logic [SPLIT_WIDTH-1:0]        fetch_split_table_num,
  input  logic                          fetch_ready,
  input  logic                          fetch_done,
  input  logic [WARP_WIDTH-1:0]         fetch_done_warp,
`ifdef GELATO_FETCH_SKD_PERF_EN
  output logic [31:0]                   perf_issue_cnt,
  output logic [31:0]                   perf_idle_cnt,
`endif
  output logic [NUM_WARPS-1:0]          sched_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1
  } state_t;

  state_t state, state_n;

  logic [WARP_WIDTH-1:0]  rr_ptr;
  logic [NUM_WARPS-1:0]   inflight;
  logic [NUM_WARPS-1:0]   inflight_n;
  logic [NUM_WARPS-1:0]   grant_q;
  logic [NUM_WARPS-1:0]   elig;
  logic [PC_WIDTH-1:0]    pc_arr [NUM_WARPS];
  logic [SPLIT_WIDTH-1:0] split_arr [NUM_WARPS];
  logic [WARP_WIDTH-1:0]  sel_warp;
  logic [WARP_WIDTH-1:0]  idx;
  logic                   sel_found;
  logic                   launch;
  logic                   accept;

  for (genvar i = 0; i < NUM_WARPS; i++) begin : g_unpack
    assign pc_arr[i]    = warp_pc[i*PC_WIDTH +: PC_WIDTH];
    assign split_arr[i] = warp_split[i*SPLIT_WIDTH +: SPLIT_WIDTH];
  end

  assign elig = warp_active & ~inflight;

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_warp  = '0;
    idx       = '0;
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      idx = rr_ptr + WARP_WIDTH'(k);
      if (elig[idx]) begin
        sel_found = 1'b1;
        sel_warp  = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rdy && sel_found) begin
          launch  = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (rdy && fetch_ready) begin
          accept  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Done clears ignore rdy; a same-cycle set takes priority.
  always_comb begin
    inflight_n = inflight;
    if (fetch_done)
      inflight_n[fetch_done_warp] = 1'b0;
    if (accept)
      inflight_n[fetch_warp_num] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      rr_ptr                <= '0;
      inflight              <= '0;
      grant_q               <= '0;
      fetch_valid           <= 1'b0;
      fetch_pc              <= '0;
      fetch_warp_num        <= '0;
      fetch_split_table_num <= '0;
    end else begin
      state    <= state_n;
      inflight <= inflight_n;
      grant_q  <= accept ? (NUM_WARPS'(1) << fetch_warp_num) : '0;
      if (launch) begin
        fetch_valid           <= 1'b1;
        fetch_pc              <= pc_arr[sel_warp];
        fetch_warp_num        <= sel_warp;
        fetch_split_table_num <= split_arr[sel_warp];
      end
      if (accept) begin
        fetch_valid <= 1'b0;
        rr_ptr      <= fetch_warp_num + WARP_WIDTH'(1);
      end
    end
  end

  assign sched_grant = grant_q & {NUM_WARPS{rdy}};

`ifdef GELATO_FETCH_SKD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_idle_cnt  <= '0;
    end else begin
      if (accept && perf_issue_cnt != 32'hFFFF_FFFF)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (state == IDLE && rdy && !sel_found &&
          perf_idle_cnt != 32'hFFFF_FFFF)
        perf_idle_cnt <= perf_idle_cnt + 32'd1;
    end
  end
`endif

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(fetch_done && accept &&
                fetch_done_warp == fetch_warp_num))
        else $error("done collides with accept of same warp");
      assert (state == IDLE || state == REQ)
        else $fatal(1, "illegal scheduler state");
    end
  end

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Self-checking bench for gelato_fetch_scheduler against a transaction-level model.
// Perf counter checks compile in when GELATO_FETCH_SKD_PERF_EN is defined.
module tb_gelato_fetch_scheduler;
  localparam int N  = 8;
  localparam int PW = 32;
  localparam int SW = 2;
  localparam int WW = 3;
  localparam int OW = 1 + PW + WW + SW + N;

  logic clk = 1'b0;
  logic rst_n, rdy;
  logic [N-1:0] warp_active;
  logic [N*PW-1:0] warp_pc;
  logic [N*SW-1:0] warp_split;
  logic fetch_valid, fetch_ready, fetch_done;
  logic [PW-1:0] fetch_pc;
  logic [WW-1:0] fetch_warp_num, fetch_done_warp;
  logic [SW-1:0] fetch_split_table_num;
  logic [N-1:0] sched_grant;
`ifdef GELATO_FETCH_SKD_PERF_EN
  logic [31:0] perf_issue_cnt, perf_idle_cnt;
`endif

  gelato_fetch_scheduler #(.NUM_WARPS(N), .PC_WIDTH(PW), .SPLIT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .warp_active(warp_active), .warp_pc(warp_pc), .warp_split(warp_split),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_warp_num(fetch_warp_num),
    .fetch_split_table_num(fetch_split_table_num),
    .fetch_ready(fetch_ready), .fetch_done(fetch_done),
    .fetch_done_warp(fetch_done_warp),
`ifdef GELATO_FETCH_SKD_PERF_EN
    .perf_issue_cnt(perf_issue_cnt), .perf_idle_cnt(perf_idle_cnt),
`endif
    .sched_grant(sched_grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: one pending request, per-warp busy flags.
  bit m_busy;
  int m_warp;
  logic [PW-1:0] m_pc;
  logic [SW-1:0] m_split;
  int m_ptr;
  bit m_infl[N];
  int m_grant;
  longint m_issue, m_idle;

  wire [OW-1:0] dut_out = {fetch_valid, fetch_pc, fetch_warp_num,
                           fetch_split_table_num, sched_grant};

  function automatic logic [OW-1:0] exp_out();
    logic [N-1:0] g;
    logic [WW-1:0] w;
    g = '0;
    if (m_grant >= 0 && rdy) g[m_grant] = 1'b1;
    w = WW'(m_warp);
    return {m_busy, m_pc, w, m_split, g};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_warp = 0; m_pc = '0; m_split = '0;
    m_ptr = 0; m_grant = -1; m_issue = 0; m_idle = 0;
    for (int i = 0; i < N; i++) m_infl[i] = 0;
  endtask

  task automatic set_pc(int w, logic [PW-1:0] v);
    warp_pc[w*PW +: PW] = v;
  endtask

  task automatic tick();
    bit acc, found, nb;
    bit ninf[N];
    int nw, ng, nptr, w;
    logic [PW-1:0] npc;
    logic [SW-1:0] nsp;
    acc = m_busy && fetch_ready && rdy;
    ninf = m_infl;
    if (fetch_done) ninf[fetch_done_warp] = 0;
    if (acc) ninf[m_warp] = 1;
    nb = m_busy; nw = m_warp; npc = m_pc; nsp = m_split;
    nptr = m_ptr; ng = -1;
    if (acc) begin
      nb = 0; ng = m_warp; nptr = (m_warp + 1) % N; m_issue++;
    end else if (!m_busy && rdy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        w = (m_ptr + k) % N;
        if (!found && warp_active[w] && !m_infl[w]) begin
          found = 1; nb = 1; nw = w;
          npc = warp_pc[w*PW +: PW];
          nsp = warp_split[w*SW +: SW];
        end
      end
      if (!found) m_idle++;
    end
    @(posedge clk);
    #1;
    m_busy = nb; m_warp = nw; m_pc = npc; m_split = nsp;
    m_ptr = nptr; m_grant = ng; m_infl = ninf;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; rdy = 1'b1; warp_active = '0; warp_pc = '0;
    warp_split = '0; fetch_ready = 1'b0; fetch_done = 1'b0;
    fetch_done_warp = '0;
    @(posedge clk); #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_out !== {OW{1'b0}}) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=%h", dut_out, {OW{1'b0}});
    end
  endtask

  task automatic test_single_warp();
    apply_reset();
    warp_active = 8'b0000_0100; set_pc(2, 32'h100);
    warp_split[2*SW +: SW] = 2'd3; fetch_ready = 1'b1;
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 32'h100 || fetch_warp_num !== 3'd2) begin
      errors++;
      $display("FAIL single_launch got=%b/%h/%0d want=1/100/2",
               fetch_valid, fetch_pc, fetch_warp_num);
    end
    tick();
    checks++;
    if (sched_grant !== 8'h04) begin
      errors++;
      $display("FAIL single_grant got=%h want=04", sched_grant);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (dut_out !== exp_out() || fetch_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_no_reissue got=%h want=%h", dut_out, exp_out());
      end
    end
    fetch_done = 1'b1; fetch_done_warp = 3'd2;
    tick();
    fetch_done = 1'b0;
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_warp_num !== 3'd2 || dut_out !== exp_out()) begin
      errors++;
      $display("FAIL single_reissue got=%h want=%h", dut_out, exp_out());
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int when[$];
    apply_reset();
    warp_active = '1; fetch_ready = 1'b1;
    for (int i = 0; i < N; i++) set_pc(i, 32'h1000 + 32'(i) * 4);
    for (int c = 0; c < 19; c++) begin
      tick();
      checks++;
      if (dut_out !== exp_out()) begin
        errors++;
        $display("FAIL rr_cycle got=%h want=%h", dut_out, exp_out());
      end
      fetch_done = 1'b0;
      for (int i = 0; i < N; i++)
        if (sched_grant[i]) begin
          order.push_back(i); when.push_back(c);
          fetch_done = 1'b1; fetch_done_warp = WW'(i);
        end
    end
    fetch_done = 1'b0;
    checks++;
    if (order.size() != 9) begin
      errors++;
      $display("FAIL rr_count got=%0d want=9", order.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (order[i] != i % N || (i > 0 && when[i] - when[i-1] != 2)) begin
          errors++;
          $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, order[i], i % N);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int grants;
    apply_reset();
    warp_active = 8'b0000_1000; set_pc(3, 32'h300);
    tick();
    for (int c = 0; c < 5; c++) begin
      set_pc(3, $urandom);
      tick();
      checks++;
      if (fetch_pc !== 32'h300 || fetch_valid !== 1'b1 || sched_grant !== '0) begin
        errors++;
        $display("FAIL bp_hold got=%h/%b/%h want=300/1/00",
                 fetch_pc, fetch_valid, sched_grant);
      end
    end
    fetch_ready = 1'b1;
    grants = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (dut_out !== exp_out()) begin
        errors++;
        $display("FAIL bp_cycle got=%h want=%h", dut_out, exp_out());
      end
      if (sched_grant == 8'h08) grants++;
    end
    checks++;
    if (grants != 1) begin
      errors++;
      $display("FAIL bp_single_grant got=%0d want=1", grants);
    end
  endtask

  task automatic test_rdy_freeze();
    logic [OW-1:0] held;
    apply_reset();
    warp_active = 8'b0000_0010; fetch_ready = 1'b1;
    set_pc(1, 32'h111); set_pc(2, 32'h222);
    tick(); tick();
    warp_active = 8'b0000_0100; fetch_ready = 1'b0;
    tick();
    held = dut_out;
    rdy = 1'b0; fetch_ready = 1'b1; set_pc(2, 32'h999);
    for (int c = 0; c < 3; c++) begin
      fetch_done = (c == 1); fetch_done_warp = 3'd1;
      tick();
      checks++;
      if (dut_out !== exp_out() || dut_out !== held) begin
        errors++;
        $display("FAIL rdy_freeze got=%h want=%h", dut_out, exp_out());
      end
    end
    fetch_done = 1'b0; rdy = 1'b1; warp_active = 8'b0000_0110;
    tick();
    checks++;
    if (sched_grant !== 8'h04) begin
      errors++;
      $display("FAIL rdy_resume_grant got=%h want=04", sched_grant);
    end
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_warp_num !== 3'd1 || dut_out !== exp_out()) begin
      errors++;
      $display("FAIL rdy_warp1_eligible got=%h want=%h", dut_out, exp_out());
    end
  endtask

  task automatic test_reset_midreq();
    apply_reset();
    warp_active = '1; fetch_ready = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || sched_grant !== '0 || fetch_pc !== '0) begin
      errors++;
      $display("FAIL reset_midreq got=%h want=0", dut_out);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_warp_num !== 3'd0 || dut_out !== exp_out()) begin
      errors++;
      $display("FAIL reset_restart got=%h want=%h", dut_out, exp_out());
    end
  endtask

  task automatic test_random();
    int w;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      warp_active = N'($urandom);
      for (int i = 0; i < N; i++) set_pc(i, $urandom);
      warp_split = (N*SW)'($urandom);
      fetch_ready = ($urandom % 3) != 0;
      rdy = ($urandom % 8) != 0;
      fetch_done = 1'b0;
      if ($urandom % 2 == 0) begin
        w = $urandom % N;
        if (!(m_busy && w == m_warp)) begin
          fetch_done = 1'b1; fetch_done_warp = WW'(w);
        end
      end
      tick();
      checks++;
      if (dut_out !== exp_out()) begin
        errors++;
        $display("FAIL random c=%0d got=%h want=%h", c, dut_out, exp_out());
      end
`ifdef GELATO_FETCH_SKD_PERF_EN
      checks++;
      if (perf_issue_cnt !== 32'(m_issue) || perf_idle_cnt !== 32'(m_idle)) begin
        errors++;
        $display("FAIL random_perf got=%0d/%0d want=%0d/%0d",
                 perf_issue_cnt, perf_idle_cnt, m_issue, m_idle);
      end
`endif
    end
    fetch_done = 1'b0; rdy = 1'b1;
  endtask

`ifdef GELATO_FETCH_SKD_PERF_EN
  task automatic test_perf();
    int grants;
    apply_reset();
    for (int c = 0; c < 4; c++) tick();
    warp_active = '1; fetch_ready = 1'b1;
    grants = 0;
    for (int c = 0; c < 40 && grants < 10; c++) begin
      tick();
      fetch_done = 1'b0;
      for (int i = 0; i < N; i++)
        if (sched_grant[i]) begin
          grants++; fetch_done = 1'b1; fetch_done_warp = WW'(i);
        end
    end
    fetch_done = 1'b0;
    checks++;
    if (perf_issue_cnt !== 32'd10 || perf_idle_cnt !== 32'd4) begin
      errors++;
      $display("FAIL perf_counts got=%0d/%0d want=10/4",
               perf_issue_cnt, perf_idle_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_warp();
    test_round_robin();
    test_backpressure();
    test_rdy_freeze();
    test_reset_midreq();
    test_random();
`ifdef GELATO_FETCH_SKD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
